// File: rtl/decoder_prefix_scanner.sv
// Byte-serial x86-64 prefix scanner: strips legacy/REX prefixes and emits one
// prefix bundle plus the first opcode byte per instruction.
module decoder_prefix_scanner #(
   parameter int MAX_LEN = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       flush,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       in_ready,
   output logic       pfx_valid,
   input  logic       pfx_ready,
   output logic [7:0] lock_repeat_prefix,
   output logic [7:0] segment_branch_prefix,
   output logic [7:0] operand_size_prefix,
   output logic [7:0] address_size_prefix,
   output logic [7:0] rex_prefix,
   output logic [3:0] pfx_count,
   output logic [7:0] opcode_byte0,
   output logic       pfx_err
);

   localparam logic [3:0] LP_LAST_CNT = 4'(MAX_LEN - 1);
   localparam logic [3:0] LP_ERR_CNT  = 4'(MAX_LEN);

   logic [7:0] r_g1, r_g2, r_opsz, r_adsz, r_rex;
   logic [3:0] r_cnt;
   logic [7:0] r_out_g1, r_out_g2, r_out_opsz, r_out_adsz, r_out_rex, r_out_op;
   logic [3:0] r_out_cnt;
   logic       r_out_err, r_out_valid;

   logic w_is_g1, w_is_g2, w_is_g3, w_is_g4, w_is_rex, w_is_legacy, w_is_prefix;
   logic w_in_ready, w_accept, w_limit, w_emit;
   logic [7:0] w_g1_next, w_g2_next, w_opsz_next, w_adsz_next, w_rex_next;

   assign w_is_g1     = (in_byte == 8'hF0) || (in_byte == 8'hF2) || (in_byte == 8'hF3);
   assign w_is_g2     = (in_byte == 8'h2E) || (in_byte == 8'h36) || (in_byte == 8'h3E) ||
                        (in_byte == 8'h26) || (in_byte == 8'h64) || (in_byte == 8'h65);
   assign w_is_g3     = (in_byte == 8'h66);
   assign w_is_g4     = (in_byte == 8'h67);
   assign w_is_rex    = (in_byte[7:4] == 4'h4);
   assign w_is_legacy = w_is_g1 || w_is_g2 || w_is_g3 || w_is_g4;
   assign w_is_prefix = w_is_legacy || w_is_rex;

   assign w_in_ready = !flush && (!r_out_valid || pfx_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_limit    = w_is_prefix && (r_cnt == LP_LAST_CNT);
   assign w_emit     = !w_is_prefix || w_limit;

   // For an opcode byte these equal the current working values, so the same
   // next-state set feeds the bundle both for a normal opcode and at the limit.
   assign w_g1_next   = w_is_g1 ? in_byte : r_g1;
   assign w_g2_next   = w_is_g2 ? in_byte : r_g2;
   assign w_opsz_next = w_is_g3 ? in_byte : r_opsz;
   assign w_adsz_next = w_is_g4 ? in_byte : r_adsz;
   assign w_rex_next  = w_is_rex ? in_byte : (w_is_legacy ? 8'h00 : r_rex);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_g1        <= 8'h00;
         r_g2        <= 8'h00;
         r_opsz      <= 8'h00;
         r_adsz      <= 8'h00;
         r_rex       <= 8'h00;
         r_cnt       <= 4'd0;
         r_out_g1    <= 8'h00;
         r_out_g2    <= 8'h00;
         r_out_opsz  <= 8'h00;
         r_out_adsz  <= 8'h00;
         r_out_rex   <= 8'h00;
         r_out_op    <= 8'h00;
         r_out_cnt   <= 4'd0;
         r_out_err   <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_g1        <= 8'h00;
         r_g2        <= 8'h00;
         r_opsz      <= 8'h00;
         r_adsz      <= 8'h00;
         r_rex       <= 8'h00;
         r_cnt       <= 4'd0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_out_valid && pfx_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_emit) begin
               r_out_g1    <= w_g1_next;
               r_out_g2    <= w_g2_next;
               r_out_opsz  <= w_opsz_next;
               r_out_adsz  <= w_adsz_next;
               r_out_rex   <= w_rex_next;
               r_out_op    <= in_byte;
               r_out_cnt   <= w_limit ? LP_ERR_CNT : r_cnt;
               r_out_err   <= w_limit;
               r_out_valid <= 1'b1;
               r_g1        <= 8'h00;
               r_g2        <= 8'h00;
               r_opsz      <= 8'h00;
               r_adsz      <= 8'h00;
               r_rex       <= 8'h00;
               r_cnt       <= 4'd0;
            end else begin
               r_g1   <= w_g1_next;
               r_g2   <= w_g2_next;
               r_opsz <= w_opsz_next;
               r_adsz <= w_adsz_next;
               r_rex  <= w_rex_next;
               r_cnt  <= r_cnt + 4'd1;
            end
         end
      end
   end

   assign in_ready              = w_in_ready;
   assign pfx_valid             = r_out_valid;
   assign lock_repeat_prefix    = r_out_g1;
   assign segment_branch_prefix = r_out_g2;
   assign operand_size_prefix   = r_out_opsz;
   assign address_size_prefix   = r_out_adsz;
   assign rex_prefix            = r_out_rex;
   assign pfx_count             = r_out_cnt;
   assign opcode_byte0          = r_out_op;
   assign pfx_err               = r_out_err;

endmodule

// File: tb/tb_decoder_prefix_scanner.sv
// Bench for decoder_prefix_scanner: directed cases from the decoder's
// expectations plus random byte streams checked against a list-based model.
module tb_decoder_prefix_scanner;

   localparam int MAX_LEN = 15;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       in_ready;
   logic       pfx_valid;
   logic       pfx_ready;
   logic [7:0] lock_repeat_prefix, segment_branch_prefix, operand_size_prefix;
   logic [7:0] address_size_prefix, rex_prefix, opcode_byte0;
   logic [3:0] pfx_count;
   logic       pfx_err;

   decoder_prefix_scanner #(.MAX_LEN(MAX_LEN)) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .flush                 (flush),
      .in_valid              (in_valid),
      .in_byte               (in_byte),
      .in_ready              (in_ready),
      .pfx_valid             (pfx_valid),
      .pfx_ready             (pfx_ready),
      .lock_repeat_prefix    (lock_repeat_prefix),
      .segment_branch_prefix (segment_branch_prefix),
      .operand_size_prefix   (operand_size_prefix),
      .address_size_prefix   (address_size_prefix),
      .rex_prefix            (rex_prefix),
      .pfx_count             (pfx_count),
      .opcode_byte0          (opcode_byte0),
      .pfx_err               (pfx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] g1, g2, os, as, rex, op;
      logic [3:0] cnt;
      logic       err;
   } bundle_t;

   bundle_t    exp_q[$];
   logic [7:0] work_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int grp(input logic [7:0] b);
      logic [7:0] g1_tab[3] = '{8'hF0, 8'hF2, 8'hF3};
      logic [7:0] g2_tab[6] = '{8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65};
      foreach (g1_tab[i]) if (b == g1_tab[i]) return 1;
      foreach (g2_tab[i]) if (b == g2_tab[i]) return 2;
      if (b == 8'h66) return 3;
      if (b == 8'h67) return 4;
      if (b >= 8'h40 && b <= 8'h4F) return 5;
      return 0;
   endfunction

   // Bundle from a complete prefix list: last member of each group wins, REX
   // survives only if it is the final prefix.
   function automatic bundle_t build(input logic [7:0] op, input logic err);
      bundle_t bd;
      bd = '{g1: 8'h00, g2: 8'h00, os: 8'h00, as: 8'h00, rex: 8'h00, op: op, cnt: 4'd0, err: err};
      foreach (work_q[i]) begin
         case (grp(work_q[i]))
            1: bd.g1 = work_q[i];
            2: bd.g2 = work_q[i];
            3: bd.os = work_q[i];
            4: bd.as = work_q[i];
            default: ;
         endcase
      end
      if (work_q.size() > 0 && grp(work_q[work_q.size()-1]) == 5) bd.rex = work_q[work_q.size()-1];
      bd.cnt = 4'(work_q.size());
      return bd;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      if (grp(b) != 0) begin
         work_q.push_back(b);
         if (work_q.size() == MAX_LEN) begin
            exp_q.push_back(build(b, 1'b1));
            work_q.delete();
         end
      end else begin
         exp_q.push_back(build(b, 1'b0));
         work_q.delete();
      end
   endtask

   task automatic compare_bundle(input string tag, input bundle_t e);
      check({tag, "_lock"}, lock_repeat_prefix,    e.g1);
      check({tag, "_seg"},  segment_branch_prefix, e.g2);
      check({tag, "_opsz"}, operand_size_prefix,   e.os);
      check({tag, "_adsz"}, address_size_prefix,   e.as);
      check({tag, "_rex"},  rex_prefix,            e.rex);
      check({tag, "_cnt"},  pfx_count,             e.cnt);
      check({tag, "_op"},   opcode_byte0,          e.op);
      check({tag, "_err"},  pfx_err,               e.err);
   endtask

   task automatic expect_const(input string tag, input logic [7:0] g1, input logic [7:0] g2,
                               input logic [7:0] os, input logic [7:0] as, input logic [7:0] rex,
                               input logic [3:0] cnt, input logic [7:0] op, input logic err);
      bundle_t e;
      e = '{g1: g1, g2: g2, os: os, as: as, rex: rex, op: op, cnt: cnt, err: err};
      check({tag, "_valid"}, pfx_valid, 1'b1);
      compare_bundle(tag, e);
   endtask

   // One clock cycle: called at a falling edge, returns at the next one.
   task automatic cycle(input logic v, input logic [7:0] b, input logic rdy, input logic fl);
      in_valid  = v;
      in_byte   = b;
      pfx_ready = rdy;
      flush     = fl;
      #1;
      check("in_ready", in_ready, !fl && (exp_q.size() == 0 || rdy));
      check("pfx_valid", pfx_valid, exp_q.size() != 0);
      if (pfx_valid && rdy && exp_q.size() != 0) begin
         compare_bundle("bundle", exp_q[0]);
         void'(exp_q.pop_front());
      end
      if (fl) begin
         exp_q.delete();
         work_q.delete();
      end else if (v && in_ready) begin
         model_byte(b);
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b1, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, pfx_valid, 1'b0);
      check({tag, "_err"},   pfx_err,   1'b0);
      check({tag, "_cnt"},   pfx_count, 4'd0);
      check({tag, "_fields"}, {lock_repeat_prefix, segment_branch_prefix, operand_size_prefix,
                               address_size_prefix}, 32'h0);
      check({tag, "_rexop"}, {rex_prefix, opcode_byte0}, 16'h0);
   endtask

   function automatic logic [7:0] pick_byte(input int pct);
      logic [7:0] tab[10] = '{8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65, 8'h66};
      int r = $urandom_range(99);
      if (r < pct / 2) return tab[$urandom_range(9)];
      if (r < (pct * 3) / 4) return 8'h40 + 8'($urandom_range(15));
      if (r < pct) return 8'h67;
      return 8'($urandom_range(255));
   endfunction

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; pfx_ready = 1'b0;
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("in_ready_after_reset", in_ready, 1'b1);
      @(negedge clk);

      send(8'h66); send(8'h48); send(8'h89);
      expect_const("rex_keep", 8'h00, 8'h00, 8'h66, 8'h00, 8'h48, 4'd2, 8'h89, 1'b0);

      send(8'h48); send(8'h66); send(8'h89);
      expect_const("rex_drop", 8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 4'd2, 8'h89, 1'b0);

      send(8'hF2); send(8'hF3); send(8'h26); send(8'h64); send(8'hA4);
      expect_const("last_wins", 8'hF3, 8'h64, 8'h00, 8'h00, 8'h00, 4'd4, 8'hA4, 1'b0);

      cycle(1'b1, 8'h90, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'hC3, 1'b0, 1'b0);
         expect_const("stall", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 8'h90, 1'b0);
      end
      cycle(1'b1, 8'hC3, 1'b1, 1'b0);
      expect_const("handoff", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 8'hC3, 1'b0);

      for (int i = 0; i < MAX_LEN; i++) send(8'h2E);
      expect_const("limit", 8'h00, 8'h2E, 8'h00, 8'h00, 8'h00, 4'(MAX_LEN), 8'h2E, 1'b1);
      send(8'h90);
      expect_const("after_limit", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 8'h90, 1'b0);

      send(8'h66); send(8'hF0);
      cycle(1'b1, 8'h90, 1'b1, 1'b1);
      send(8'h90);
      expect_const("after_flush", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 8'h90, 1'b0);

      send(8'h66); send(8'hF0);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      work_q.delete();
      send(8'h90);
      expect_const("after_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 8'h90, 1'b0);

      for (int c = 0; c < 3000; c++) begin
         int pct = ((c / 200) % 4 == 3) ? 97 : 55;
         cycle(($urandom_range(99) < 75), pick_byte(pct), ($urandom_range(99) < 70),
               ($urandom_range(99) < 2));
      end
      for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_prefix_scanner.md
# decoder_prefix_scanner

Byte-serial front stage of the x86-64 decoder. Consumes the instruction byte stream from the fetch buffer, strips legacy prefixes and REX, and emits one prefix bundle per instruction together with the first opcode byte. Its outputs load the prefix fields and opcode lookup key of `fat_instruction_t` in the decode stage directly downstream.

## Interface
Parameters:
- `MAX_LEN`, default 15: architectural instruction length limit. The prefix count limit is `MAX_LEN-1`.

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous discard of all scan state (branch redirect)
- `in_valid`  in  1  `in_byte` is valid
- `in_byte`  in  8  next instruction-stream byte
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `pfx_valid`  out  1  prefix bundle valid
- `pfx_ready`  in  1  downstream accepts bundle
- `lock_repeat_prefix`  out  8  last group-1 prefix (F0/F2/F3), else 00
- `segment_branch_prefix`  out  8  last group-2 prefix (2E/36/3E/26/64/65), else 00
- `operand_size_prefix`  out  8  66 if present, else 00
- `address_size_prefix`  out  8  67 if present, else 00
- `rex_prefix`  out  8  REX byte (40–4F) if it immediately precedes the opcode, else 00
- `pfx_count`  out  4  number of prefix bytes consumed, including discarded REX
- `opcode_byte0`  out  8  first non-prefix byte
- `pfx_err`  out  1  length limit exceeded

## Operation
- State: working prefix registers, `cnt[3:0]`, output bundle registers, and `pfx_valid`.
- `in_ready = !flush && (!pfx_valid || pfx_ready)`.
- Per accepted byte, classification is mutually exclusive:
  - **Group 1–4 legacy prefix:**
    - Overwrite the group's working register; the last prefix in a group wins.
    - Clear working REX, because REX is discarded when a legacy prefix follows it.
    - `cnt++`.
  - **REX (40–4F):**
    - Overwrite working REX; the last REX wins.
    - `cnt++`.
  - **Any other byte (opcode):**
    - Copy the working prefixes, `cnt`, and the byte into the output registers.
    - Set `pfx_valid=1` and `pfx_err=0`.
    - Clear the working registers and `cnt`.
- Length limit:
  - Applies when a prefix or REX byte is accepted while `cnt == MAX_LEN-1`.
  - Emit a bundle with `pfx_err=1`, `pfx_count=MAX_LEN`, `opcode_byte0` set to that byte, and the prefix fields as accumulated, including that byte.
  - Clear working state.
- Output handshake:
  - Bundle is held stable while `pfx_valid && !pfx_ready`.
  - On `pfx_valid && pfx_ready`, `pfx_valid` clears the next cycle unless an opcode byte is accepted in the same cycle, in which case the new bundle replaces it with `pfx_valid` remaining 1.
  - Prefix bytes accepted in the handoff cycle go into the already-cleared working registers, so they never merge with the departing bundle.
- `flush`:
  - Clears working registers, `cnt`, and `pfx_valid` next cycle; an undelivered bundle is dropped.
  - No byte is accepted during `flush`.
  - `flush` has priority over all other events.

## Timing
- Reset (async assert, `reset_n=0`): `pfx_valid=0`, `pfx_err=0`, `pfx_count=0`, all prefix outputs 00, `opcode_byte0=00`.
- After reset, `in_ready=1` once `reset_n` is deasserted.
- One byte per cycle maximum.
- Latency: opcode byte accepted in cycle N → `pfx_valid=1` in cycle N+1, registered.
- Throughput:
  - One bundle per cycle for prefix-free opcodes when `pfx_ready` is held high.
  - An instruction with k prefixes occupies k+1 input cycles.
- Reset mid-scan or mid-hold discards everything; no partial bundle is emitted.
- `in_valid=0` cycles between prefix bytes preserve working state indefinitely.
- Outputs while `pfx_valid=0` are don't-care except at reset; the bench checks them only under `pfx_valid`.

## Test plan
- **REX before opcode:**
  - Stimulus: bytes 66,48,89 back-to-back, `pfx_ready=1`.
  - Required: one bundle in the cycle after 89 is accepted; `operand_size_prefix=66`, `rex_prefix=48`, `pfx_count=2`, `opcode_byte0=89`, `pfx_err=0`, other fields 00.
- **REX discard:**
  - Stimulus: 48,66,89.
  - Required: `rex_prefix=00`, `operand_size_prefix=66`, `pfx_count=2`.
- **Last-wins in a group:**
  - Stimulus: F2,F3,26,64,A4.
  - Required: `lock_repeat_prefix=F3`, `segment_branch_prefix=64`, `pfx_count=4`, `opcode_byte0=A4`.
- **Backpressure:**
  - Stimulus: 90 with `pfx_ready=0` for 3 cycles.
  - Required during the stall: `in_ready=0` and the bundle stable.
  - Stimulus: raise `pfx_ready` while presenting C3.
  - Required: C3 accepted that cycle; next cycle `pfx_valid=1` with `opcode_byte0=C3` and `pfx_count=0`, with no idle gap.
- **Length limit:**
  - Stimulus: 15 consecutive 2E bytes.
  - Required: after the 15th byte, bundle has `pfx_err=1`, `pfx_count=15`, `segment_branch_prefix=2E`, `opcode_byte0=2E`.
  - Stimulus: next byte 90.
  - Required: clean bundle with `pfx_count=0` and `pfx_err=0`.
- **Flush/reset mid-instruction:**
  - Stimulus: 66,F0, then `flush` for 1 cycle, then 90.
  - Required: `in_ready=0` during `flush`; the bundle for 90 has all prefixes 00 and `pfx_count=0`.
  - Stimulus: repeat with an async `reset_n` pulse in place of `flush`.
  - Required: the same bundle, and all outputs read 00 while reset is asserted.
